// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS byte stream: width, taps, step function, checker states.
// popcount8 is only referenced when LFSR_CHK_BITERR_EN is defined.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  // Feedback taps s[7], s[5], s[4], s[3]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-seeds from the stream, locks after LOCK_COUNT predicted matches,
// counts errors while locked. Define LFSR_CHK_BITERR_EN to count bit errors instead of word errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              clr_err,
  output logic              locked,
  output logic              sync_lost,
  output logic [ERR_W-1:0]  err_count,
  output logic [7:0]        expected_out
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  chk_state_t         state_q, state_d;
  logic               seeded_q, seeded_d;
  logic [MATCH_W-1:0] match_run_q, match_run_d, match_inc;
  logic [MISS_W-1:0]  miss_run_q, miss_run_d, miss_inc;
  logic [7:0]         expected_q, expected_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d, err_next;
  logic               sync_lost_q, sync_lost_d;
  logic               locked_q, locked_d;
  logic [7:0]         diff;
  logic               mismatch;

  assign diff      = data_in ^ expected_q;
  assign mismatch  = |diff;
  assign match_inc = match_run_q + MATCH_W'(1);
  assign miss_inc  = miss_run_q + MISS_W'(1);

`ifdef LFSR_CHK_BITERR_EN
  // One spare bit catches the carry out of a popcount add (assumes ERR_W >= 4)
  logic [ERR_W:0] err_sum;
  assign err_sum  = {1'b0, err_count_q} + (ERR_W + 1)'(popcount8(diff));
  assign err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
`else
  assign err_next = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);
`endif

  always_comb begin
    state_d     = state_q;
    seeded_d    = seeded_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    expected_d  = expected_q;
    err_count_d = err_count_q;
    sync_lost_d = 1'b0;
    if (data_valid) begin
      case (state_q)
        SEARCH: begin
          if (data_in == 8'h00) begin
            // All-zero is the LFSR lockup value; never seed from it
            seeded_d    = 1'b0;
            match_run_d = '0;
          end else if (!seeded_q || mismatch) begin
            expected_d  = lfsr_step(data_in);
            seeded_d    = 1'b1;
            match_run_d = '0;
          end else begin
            expected_d  = lfsr_step(expected_q);
            match_run_d = match_inc;
            if (match_inc == MATCH_W'(LOCK_COUNT)) begin
              state_d    = LOCKED;
              miss_run_d = '0;
            end
          end
        end
        default: begin
          expected_d = lfsr_step(expected_q);
          if (!mismatch) begin
            miss_run_d = '0;
          end else begin
            err_count_d = err_next;
            miss_run_d  = miss_inc;
            if (miss_inc == MISS_W'(LOSS_COUNT)) begin
              state_d     = SEARCH;
              sync_lost_d = 1'b1;
              miss_run_d  = '0;
              match_run_d = '0;
              seeded_d    = (data_in != 8'h00);
              if (data_in != 8'h00) expected_d = lfsr_step(data_in);
            end
          end
        end
      endcase
    end
    if (clr_err) err_count_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      seeded_q    <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      expected_q  <= '0;
      err_count_q <= '0;
      sync_lost_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seeded_q    <= seeded_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      sync_lost_q <= sync_lost_d;
      locked_q    <= locked_d;
    end
  end

  assign locked       = locked_q;
  assign sync_lost    = sync_lost_q;
  assign err_count    = err_count_q;
  assign expected_out = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, stay-locked, single errors, loss of sync, zero stream,
// clr_err priority, saturation on a narrow (ERR_W=4) instance, and mid-stream reset.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        clr_err;
  logic        locked, sync_lost, locked_s, sync_lost_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;
  logic [7:0]  expected_out, expected_out_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(3), .LOSS_COUNT(4), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr_err(clr_err),
    .locked(locked), .sync_lost(sync_lost), .err_count(err_count), .expected_out(expected_out)
  );

  lfsr_checker #(.LOCK_COUNT(3), .LOSS_COUNT(4), .ERR_W(4)) u_dut_s (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr_err(clr_err),
    .locked(locked_s), .sync_lost(sync_lost_s), .err_count(err_count_s), .expected_out(expected_out_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the same point
  task automatic send(input logic [7:0] b, input logic clr = 1'b0);
    data_in    = b;
    data_valid = 1'b1;
    clr_err    = clr;
    @(posedge clk); #1;
    data_valid = 1'b0;
    clr_err    = 1'b0;
  endtask

  task automatic idle(input logic clr = 1'b0);
    data_valid = 1'b0;
    clr_err    = clr;
    @(posedge clk); #1;
    clr_err    = 1'b0;
  endtask

  // Stream generator for long runs; checked values below are hand-derived constants
  function automatic logic [7:0] nxt(input logic [7:0] b);
    return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
  endfunction

  initial begin : main
    logic [7:0] e;
    rst = 1'b1; data_in = '0; data_valid = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_locked", locked, 0);
    chk("rst_sync_lost", sync_lost, 0);
    chk("rst_err", err_count, 0);
    chk("rst_expected", expected_out, 8'h00);

    // Lock on 01,02,04,08
    send(8'h01); send(8'h02); send(8'h04);
    chk("t1_not_yet", locked, 0);
    send(8'h08);
    chk("t1_locked", locked, 1);
    chk("t1_err", err_count, 0);
    chk("t1_expected", expected_out, 8'h11);

    // Continue clean stream
    send(8'h11); send(8'h23);
    chk("t2_locked", locked, 1);
    chk("t2_err", err_count, 0);
    chk("t2_expected", expected_out, 8'h47);

    // One single-bit corrupted byte (0x47 sent as 0x46), then a correct byte
    send(8'h46);
    chk("t3_err", err_count, 1);
    chk("t3_locked", locked, 1);
    chk("t3_expected", expected_out, 8'h8E);
    send(8'h8E);
    chk("t3_err_hold", err_count, 1);
    chk("t3_still_locked", locked, 1);

    // Valid gaps keep lock and prediction; clr_err works without data_valid
    idle(); idle(); idle();
    chk("gap_locked", locked, 1);
    chk("gap_expected", expected_out, 8'h1C);
    idle(1'b1);
    chk("clr_idle", err_count, 0);
    chk("clr_idle_s", err_count_s, 0);

    // Four consecutive bad bytes (expected 1C,38,71,E2, each with bit0 flipped)
    send(8'h1D); send(8'h39); send(8'h70);
    chk("t4_locked_3bad", locked, 1);
    chk("t4_no_pulse_yet", sync_lost, 0);
    send(8'hE3);
    chk("t4_sync_lost", sync_lost, 1);
    chk("t4_unlocked", locked, 0);
    chk("t4_err", err_count, 4);
    idle();
    chk("t4_pulse_end", sync_lost, 0);
    chk("t4_err_hold", err_count, 4);
    // Restart stream: 01 reseeds, then 02,04,08 relock
    send(8'h01); send(8'h02); send(8'h04);
    chk("t4_relock_wait", locked, 0);
    send(8'h08);
    chk("t4_relocked", locked, 1);
    chk("t4_relock_exp", expected_out, 8'h11);
    chk("t4_relock_pulse", sync_lost, 0);

    // clr_err on an errored word: clear wins over the increment
    send(8'h10, 1'b1);
    chk("t6_clr_wins", err_count, 0);
    chk("t6_clr_wins_s", err_count_s, 0);
    chk("t6_expected", expected_out, 8'h23);

    // 17 alternating bad/good words: wide counter reaches 17, narrow one saturates at 0xF
    e = 8'h23;
    for (int k = 0; k < 17; k++) begin
      send(e ^ 8'h01);
      e = nxt(e);
      send(e);
      e = nxt(e);
      if (k == 14) chk("t6_at_15_s", err_count_s, 4'hF);
    end
    chk("t6_sat_s", err_count_s, 4'hF);
    chk("t6_wide", err_count, 17);
    chk("t6_still_locked", locked, 1);
    chk("t6_still_locked_s", locked_s, 1);

    // Reset while locked
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_err", err_count, 0);
    chk("t6_rst_err_s", err_count_s, 0);
    chk("t6_rst_expected", expected_out, 8'h00);
    chk("t6_rst_sync_lost", sync_lost, 0);

    // Zero stream never seeds or locks
    for (int k = 0; k < 5; k++) send(8'h00);
    chk("t5_zero_unlocked", locked, 0);
    chk("t5_zero_expected", expected_out, 8'h00);
    send(8'h01); send(8'h02); send(8'h04);
    chk("t5_wait", locked, 0);
    send(8'h08);
    chk("t5_locked", locked, 1);
    chk("t5_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
